// File: rtl/huff_sort3_pkg.sv
// huff_sort3_pkg: node geometry and weight extraction shared by the huffman sorter.
package huff_pkg;
  localparam int NODE_W = 8;
  localparam int KEY_W  = 4;
  typedef logic [NODE_W-1:0] node_t;
  function automatic logic [KEY_W-1:0] weight_of(input node_t n);
    return n[KEY_W-1:0];
  endfunction
endpackage

// File: rtl/huff_sort3_if.sv
// huff_sort3_if: three unsorted nodes in, three weight-ordered nodes out.
interface huff_sort3_if;
  import huff_pkg::*;
  node_t node1, node2, node3;
  node_t new1, new2, new3;
  modport master (output node1, node2, node3, input new1, new2, new3);
  modport slave (input node1, node2, node3, output new1, new2, new3);
endinterface

// File: rtl/huff_cmp_swap.sv
// huff_cmp_swap: compare-exchange on weight; a tie keeps a ahead of b.
module huff_cmp_swap
  import huff_pkg::*;
(
  input  node_t a_i,
  input  node_t b_i,
  output node_t lo_o,
  output node_t hi_o
);
  logic swap;
  always_comb begin
    swap = weight_of(a_i) > weight_of(b_i);
    lo_o = swap ? b_i : a_i;
    hi_o = swap ? a_i : b_i;
  end
endmodule

// File: rtl/huff_sort3.sv
// huff_sort3: registered stable 3-node sort by ascending weight, 1-cycle latency.
module huff_sort3
  import huff_pkg::*;
(
  input logic         CLK,
  input logic         nRST,
  huff_sort3_if.slave io
);
  node_t x0, x1, y1, new1_d, new2_d, new3_d;
  node_t new1_q, new2_q, new3_q;
  huff_cmp_swap u_cs0 (.a_i(io.node1), .b_i(io.node2), .lo_o(x0), .hi_o(x1));
  huff_cmp_swap u_cs1 (.a_i(x1), .b_i(io.node3), .lo_o(y1), .hi_o(new3_d));
  huff_cmp_swap u_cs2 (.a_i(x0), .b_i(y1), .lo_o(new1_d), .hi_o(new2_d));
  // nRST is active-high despite its name
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      new1_q <= '0;
      new2_q <= '0;
      new3_q <= '0;
    end else begin
      new1_q <= new1_d;
      new2_q <= new2_d;
      new3_q <= new3_d;
    end
  end
  assign io.new1 = new1_q;
  assign io.new2 = new2_q;
  assign io.new3 = new3_q;
endmodule

// File: tb/tb_huff_sort3.sv
// tb_huff_sort3: directed checks of reset, ordering, ties, streaming and async reset.
module tb_huff_sort3;
  logic CLK = 1'b0;
  logic nRST = 1'b1;
  int checks = 0;
  int failures = 0;
  huff_sort3_if bus ();
  huff_sort3 dut (.CLK(CLK), .nRST(nRST), .io(bus.slave));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [23:0] exp);
    logic [23:0] obs;
    obs = {bus.new1, bus.new2, bus.new3};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    bus.node1 = a;
    bus.node2 = b;
    bus.node3 = c;
  endtask
  logic [7:0] perm [6][3];
  initial begin
    perm[0] = '{8'hA1, 8'hB7, 8'hCF};
    perm[1] = '{8'hA1, 8'hCF, 8'hB7};
    perm[2] = '{8'hB7, 8'hA1, 8'hCF};
    perm[3] = '{8'hB7, 8'hCF, 8'hA1};
    perm[4] = '{8'hCF, 8'hA1, 8'hB7};
    perm[5] = '{8'hCF, 8'hB7, 8'hA1};
    drive(8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(8'($urandom), 8'($urandom), 8'($urandom));
      @(negedge CLK);
      chk("reset_hold", 24'h000000);
    end
    drive(8'h2A, 8'h3B, 8'h1C);
    nRST = 1'b0;
    #1 chk("release_no_early", 24'h000000);
    @(negedge CLK);
    chk("basic", 24'h2A3B1C);
    drive(8'h1C, 8'h3B, 8'h2A);
    #1 chk("no_comb_path", 24'h2A3B1C);
    @(negedge CLK);
    chk("reverse", 24'h2A3B1C);
    drive(8'h55, 8'h15, 8'h93);
    @(negedge CLK);
    chk("ties_stable", 24'h935515);
    drive(8'h34, 8'h64, 8'h94);
    @(negedge CLK);
    chk("all_equal", 24'h346494);
    drive(8'h0F, 8'h10, 8'hE0);
    @(negedge CLK);
    chk("boundary_w", 24'h10E00F);
    drive(perm[0][0], perm[0][1], perm[0][2]);
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      chk($sformatf("stream_%0d", k - 1), 24'hA1B7CF);
      if (k < 6) drive(perm[k][2], perm[k][0], perm[k][1]);
    end
    drive(8'h72, 8'h81, 8'h93);
    @(negedge CLK);
    chk("pre_reset", 24'h817293);
    drive(8'h4E, 8'h5D, 8'h6C);
    #2 nRST = 1'b1;
    #1 chk("async_reset", 24'h000000);
    @(negedge CLK);
    chk("reset_discard", 24'h000000);
    drive(8'h2A, 8'h1C, 8'h3B);
    nRST = 1'b0;
    @(negedge CLK);
    chk("post_reset", 24'h2A3B1C);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
